mem_port_arbiter: RTL and testbench

Shares the single external memory port between the I-cache line-fill engine and the D-cache fill/write-back engine. Grants are per burst: the block grants the port to one requester for a whole 16-beat burst, forwards that requester's per-beat address, write data and write-enable to memory, and routes the per-beat responses back to it only. When both requesters wait, it alternates between them round-robin. It sits between the two cache controllers and the memory interface.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding,
// owner identifiers and the default burst geometry.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IC   = 2'd1,
      ARB_DC   = 2'd2
   } arb_state_t;

   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   // Counter width that can hold 0..beats-1, never narrower than one bit.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   localparam int DEF_BEATS = 16;
   localparam int DEF_CNT_W = cnt_width(DEF_BEATS);

   function automatic arb_state_t owner_state(input logic owner);
      return (owner == OWN_DC) ? ARB_DC : ARB_IC;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker; on contention the requester that did not
// own the port last wins. Purely combinational.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       winner
);

   always_comb begin
      winner = OWN_IC;
      unique case (req)
         2'b01:   winner = OWN_IC;
         2'b10:   winner = OWN_DC;
         2'b11:   winner = ~last_owner;
         default: winner = OWN_IC;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the I-cache and D-cache fill engines,
// granting whole bursts and alternating owners round-robin under contention.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BEATS  = DEF_BEATS,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_resp_valid,
   output logic [DATA_W-1:0] ic_resp_data,
   output logic              ic_grant,
   input  logic              dc_req_valid,
   input  logic              dc_req_we,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_resp_valid,
   output logic [DATA_W-1:0] dc_resp_data,
   output logic              dc_grant,
   output logic              mem_req_valid,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err_spurious
);

   localparam int CNT_W = cnt_width(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             last_owner_q, last_owner_d;
   logic             err_q, err_d;
   logic             winner;
   logic             final_beat;

   rr_arb2 u_rr_arb2 (
      .req        ({dc_req_valid, ic_req_valid}),
      .last_owner (last_owner_q),
      .winner     (winner)
   );

   assign final_beat = (state_q != ARB_IDLE) && mem_resp_valid && (beat_cnt_q == LAST_BEAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         beat_cnt_q   <= '0;
         last_owner_q <= OWN_DC;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         last_owner_q <= last_owner_d;
         err_q        <= err_d;
      end
   end

   // On the final beat the owner's own valid is ignored: only the other side
   // can take the port directly, so nobody gets back-to-back bursts.
   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      last_owner_d = last_owner_q;
      err_d        = err_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (mem_resp_valid) begin
               err_d = 1'b1;
            end
            if (ic_req_valid || dc_req_valid) begin
               state_d    = owner_state(winner);
               beat_cnt_d = '0;
            end
         end
         ARB_IC: begin
            if (final_beat) begin
               last_owner_d = OWN_IC;
               beat_cnt_d   = '0;
               state_d      = dc_req_valid ? ARB_DC : ARB_IDLE;
            end else if (mem_resp_valid) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         ARB_DC: begin
            if (final_beat) begin
               last_owner_d = OWN_DC;
               beat_cnt_d   = '0;
               state_d      = ic_req_valid ? ARB_IC : ARB_IDLE;
            end else if (mem_resp_valid) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

   // The I-cache only ever reads, so its write enable and data are forced low.
   always_comb begin
      ic_grant      = 1'b0;
      dc_grant      = 1'b0;
      ic_resp_valid = 1'b0;
      dc_resp_valid = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_wdata     = '0;
      unique case (state_q)
         ARB_IC: begin
            ic_grant      = 1'b1;
            ic_resp_valid = mem_resp_valid;
            mem_req_valid = ic_req_valid;
            mem_req_addr  = ic_req_addr;
         end
         ARB_DC: begin
            dc_grant      = 1'b1;
            dc_resp_valid = mem_resp_valid;
            mem_req_valid = dc_req_valid;
            mem_req_we    = dc_req_we;
            mem_req_addr  = dc_req_addr;
            mem_wdata     = dc_wdata;
         end
         default: begin
            ic_grant = 1'b0;
         end
      endcase
   end

   assign ic_resp_data = mem_rdata;
   assign dc_resp_data = mem_rdata;
   assign err_spurious = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter, checked every cycle against a
// burst-level reference model of owner, beats served and fairness history.
module tb_mem_port_arbiter;

   localparam int BEATS = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ic_req_valid = 1'b0;
   logic [31:0] ic_req_addr = '0;
   logic        ic_resp_valid;
   logic [31:0] ic_resp_data;
   logic        ic_grant;
   logic        dc_req_valid = 1'b0;
   logic        dc_req_we = 1'b0;
   logic [31:0] dc_req_addr = '0;
   logic [31:0] dc_wdata = '0;
   logic        dc_resp_valid;
   logic [31:0] dc_resp_data;
   logic        dc_grant;
   logic        mem_req_valid;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        err_spurious;

   mem_port_arbiter #(.BEATS(BEATS), .ADDR_W(32), .DATA_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ic_req_valid   (ic_req_valid),
      .ic_req_addr    (ic_req_addr),
      .ic_resp_valid  (ic_resp_valid),
      .ic_resp_data   (ic_resp_data),
      .ic_grant       (ic_grant),
      .dc_req_valid   (dc_req_valid),
      .dc_req_we      (dc_req_we),
      .dc_req_addr    (dc_req_addr),
      .dc_wdata       (dc_wdata),
      .dc_resp_valid  (dc_resp_valid),
      .dc_resp_data   (dc_resp_data),
      .dc_grant       (dc_grant),
      .mem_req_valid  (mem_req_valid),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_wdata      (mem_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_rdata      (mem_rdata),
      .err_spurious   (err_spurious)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: owner 0 = none, 1 = I-cache, 2 = D-cache; m_last 1 means D-cache served last.
   int m_owner = 0;
   int m_beats = 0;
   int m_last = 1;
   int m_bursts = 0;
   bit m_err = 1'b0;

   int ic_pulses = 0;
   int dc_pulses = 0;
   int prev_grant = 0;
   int handovers = 0;
   int owner_log[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      m_owner = 0;
      m_beats = 0;
      m_last = 1;
      m_err = 1'b0;
   endtask

   task automatic compareAll();
      int cur;
      checkOutput("ic_grant", {31'd0, ic_grant}, (m_owner == 1) ? 32'd1 : 32'd0);
      checkOutput("dc_grant", {31'd0, dc_grant}, (m_owner == 2) ? 32'd1 : 32'd0);
      checkOutput("mem_req_valid", {31'd0, mem_req_valid},
                  (m_owner == 1) ? {31'd0, ic_req_valid} : (m_owner == 2) ? {31'd0, dc_req_valid} : 32'd0);
      checkOutput("mem_req_we", {31'd0, mem_req_we}, (m_owner == 2) ? {31'd0, dc_req_we} : 32'd0);
      checkOutput("mem_req_addr", mem_req_addr,
                  (m_owner == 1) ? ic_req_addr : (m_owner == 2) ? dc_req_addr : 32'd0);
      checkOutput("mem_wdata", mem_wdata, (m_owner == 2) ? dc_wdata : 32'd0);
      checkOutput("ic_resp_valid", {31'd0, ic_resp_valid}, (m_owner == 1) ? {31'd0, mem_resp_valid} : 32'd0);
      checkOutput("dc_resp_valid", {31'd0, dc_resp_valid}, (m_owner == 2) ? {31'd0, mem_resp_valid} : 32'd0);
      checkOutput("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
      if (rst_n) begin
         checkOutput("ic_resp_data", ic_resp_data, mem_rdata);
         checkOutput("dc_resp_data", dc_resp_data, mem_rdata);
      end
      if (ic_resp_valid === 1'b1) ic_pulses++;
      if (dc_resp_valid === 1'b1) dc_pulses++;
      cur = (ic_grant === 1'b1) ? 1 : (dc_grant === 1'b1) ? 2 : 0;
      if (cur != 0 && cur != prev_grant) begin
         owner_log.push_back(cur);
         if (prev_grant != 0) handovers++;
      end
      prev_grant = cur;
   endtask

   task automatic updateModel();
      bit other_valid;
      if (!rst_n) begin
         resetModel();
      end else if (m_owner == 0) begin
         if (mem_resp_valid) m_err = 1'b1;
         m_beats = 0;
         if (ic_req_valid && dc_req_valid) m_owner = (m_last == 1) ? 1 : 2;
         else if (ic_req_valid) m_owner = 1;
         else if (dc_req_valid) m_owner = 2;
      end else if (mem_resp_valid) begin
         m_beats++;
         if (m_beats == BEATS) begin
            m_last = (m_owner == 1) ? 0 : 1;
            m_bursts++;
            other_valid = (m_owner == 1) ? dc_req_valid : ic_req_valid;
            m_owner = other_valid ? ((m_owner == 1) ? 2 : 1) : 0;
            m_beats = 0;
         end
      end
   endtask

   task automatic applyStimulus(input logic icv, input logic [31:0] ica, input logic dcv, input logic dcwe,
                                input logic [31:0] dca, input logic [31:0] dcwd, input logic mrv,
                                input logic [31:0] mrd);
      ic_req_valid = icv;
      ic_req_addr = ica;
      dc_req_valid = dcv;
      dc_req_we = dcwe;
      dc_req_addr = dca;
      dc_wdata = dcwd;
      mem_resp_valid = mrv;
      mem_rdata = mrd;
      #1;
      compareAll();
      @(posedge clk);
      updateModel();
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      resetModel();
      compareAll();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      prev_grant = 0;
   endtask

   initial begin
      int start_bursts;
      int cyc;
      int gap;
      int ic_before;
      int dc_before;
      bit served;
      logic icv;
      logic dcv;

      ic_req_valid = 1'b0;
      #2;
      doReset();
      idleCycle();

      // Simultaneous requests from reset, continuing for four bursts.
      owner_log.delete();
      handovers = 0;
      start_bursts = m_bursts;
      cyc = 0;
      while (m_bursts - start_bursts < 4 && cyc < 200) begin
         icv = 1'b1;
         dcv = 1'b1;
         if (m_bursts - start_bursts == 3 && m_beats == BEATS - 1) begin
            icv = 1'b0;
            dcv = 1'b0;
         end
         applyStimulus(icv, $urandom, dcv, 1'b1, $urandom, $urandom, (m_owner != 0), $urandom);
         cyc++;
      end
      checkOutput("fair_done", {31'd0, (cyc < 200)}, 32'd1);
      checkOutput("fair_bursts", owner_log.size(), 32'd4);
      if (owner_log.size() == 4) begin
         checkOutput("fair_owner0", owner_log[0], 32'd1);
         checkOutput("fair_owner1", owner_log[1], 32'd2);
         checkOutput("fair_owner2", owner_log[2], 32'd1);
         checkOutput("fair_owner3", owner_log[3], 32'd2);
      end
      checkOutput("fair_handovers", handovers, 32'd3);
      idleCycle();

      // I-cache alone, critical word at 0x0000_1040, no memory gaps.
      ic_before = ic_pulses;
      dc_before = dc_pulses;
      served = 1'b0;
      cyc = 0;
      while (!(served && m_owner == 0) && cyc < 40) begin
         if (m_owner != 0) served = 1'b1;
         applyStimulus(1'b1, 32'h0000_1040 + 32'(m_beats * 4), 1'b0, 1'b0, '0, '0, (m_owner != 0), $urandom);
         cyc++;
      end
      checkOutput("ic_alone_cycles", cyc, 32'd17);
      checkOutput("ic_alone_pulses", ic_pulses - ic_before, 32'd16);
      checkOutput("ic_alone_dc_pulses", dc_pulses - dc_before, 32'd0);
      idleCycle();

      // D-cache fill with random memory wait states.
      dc_before = dc_pulses;
      served = 1'b0;
      cyc = 0;
      gap = $urandom_range(0, 5);
      while (!(served && m_owner == 0) && cyc < 200) begin
         logic mrv;
         mrv = 1'b0;
         if (m_owner != 0) begin
            served = 1'b1;
            if (gap > 0) gap--;
            else begin
               mrv = 1'b1;
               gap = $urandom_range(0, 5);
            end
         end
         applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_2000 + 32'(m_beats * 4), '0, mrv, $urandom);
         cyc++;
      end
      checkOutput("dc_wait_done", {31'd0, (cyc < 200)}, 32'd1);
      checkOutput("dc_wait_pulses", dc_pulses - dc_before, 32'd16);
      idleCycle();

      // Random traffic, including owners dropping valid mid-burst.
      for (int i = 0; i < 600; i++) begin
         icv = (m_owner == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
         dcv = (m_owner == 2) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
         applyStimulus(icv, $urandom, dcv, 1'($urandom), $urandom, $urandom,
                       (m_owner != 0) && ($urandom_range(0, 9) < 6), $urandom);
      end
      idleCycle();

      // Reset at beat 7 of an I-cache burst, then a spurious response in IDLE.
      cyc = 0;
      while (!(m_owner == 1 && m_beats == 6) && cyc < 40) begin
         applyStimulus(1'b1, $urandom, 1'b0, 1'b0, '0, '0, (m_owner != 0), $urandom);
         cyc++;
      end
      checkOutput("beat7_reached", {31'd0, (cyc < 40)}, 32'd1);
      ic_req_valid = 1'b1;
      mem_resp_valid = 1'b1;
      mem_rdata = $urandom;
      #1;
      doReset();
      checkOutput("reset_mem_valid", {31'd0, mem_req_valid}, 32'd0);
      idleCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, $urandom);
      repeat (4) idleCycle();
      checkOutput("err_sticky", {31'd0, err_spurious}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
